// File: rtl/tbird_light_ctrl.sv
// Thunderbird tail-light sequencer: synchronises the LEFT/RIGHT/HAZARD switches,
// divides clk down to a sequencing tick and steps a Moore FSM that drives the
// six tail lamps and the mode code shown on the hex display.
module tbird_light_ctrl #(
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       haz_sw,
    output logic [5:0] lights,
    output logic [3:0] csl,
    output logic       tick
);

    localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    localparam logic [3:0] CSL_IDLE   = 4'd0;
    localparam logic [3:0] CSL_LEFT   = 4'd1;
    localparam logic [3:0] CSL_RIGHT  = 4'd2;
    localparam logic [3:0] CSL_HAZARD = 4'd3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_L1     = 4'd1,
        ST_L2     = 4'd2,
        ST_L3     = 4'd3,
        ST_R1     = 4'd4,
        ST_R2     = 4'd5,
        ST_R3     = 4'd6,
        ST_HZ_ON  = 4'd7,
        ST_HZ_OFF = 4'd8
    } state_e;

    // Synchroniser stages, bit order {left, right, hazard}
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic             sl_s;
    logic             sr_s;
    logic             hz_s;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    state_e           state_q;
    state_e           state_d;

    logic [5:0]       lights_q;
    logic [5:0]       lights_d;
    logic [3:0]       csl_q;
    logic [3:0]       csl_d;

    // Two-flop synchroniser for the three asynchronous switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {left_sw, right_sw, haz_sw};
            sync2_q <= sync1_q;
        end
    end

    // Left and right together are treated exactly like the hazard switch
    assign sl_s = sync2_q[2];
    assign sr_s = sync2_q[1];
    assign hz_s = sync2_q[0] | (sync2_q[2] & sync2_q[1]);

    // Prescaler next count: wraps after TICK_DIV-1
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler and tick register; tick is high while the count sits at TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    // State register; next state already holds between ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, evaluated only on tick cycles; hazard always wins
    always_comb begin
        state_d = state_q;
        if (tick_q) begin
            case (state_q)
                ST_IDLE, ST_HZ_OFF: begin
                    if (hz_s) begin
                        state_d = ST_HZ_ON;
                    end else if (sl_s) begin
                        state_d = ST_L1;
                    end else if (sr_s) begin
                        state_d = ST_R1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_L1:    state_d = hz_s ? ST_HZ_ON : ST_L2;
                ST_L2:    state_d = hz_s ? ST_HZ_ON : ST_L3;
                ST_L3:    state_d = hz_s ? ST_HZ_ON : ST_IDLE;
                ST_R1:    state_d = hz_s ? ST_HZ_ON : ST_R2;
                ST_R2:    state_d = hz_s ? ST_HZ_ON : ST_R3;
                ST_R3:    state_d = hz_s ? ST_HZ_ON : ST_IDLE;
                ST_HZ_ON: state_d = ST_HZ_OFF;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Moore decode of the upcoming state, so the registered outputs track the state register
    always_comb begin
        lights_d = 6'b000000;
        csl_d    = CSL_IDLE;
        case (state_d)
            ST_IDLE:   begin lights_d = 6'b000000; csl_d = CSL_IDLE;   end
            ST_L1:     begin lights_d = 6'b001000; csl_d = CSL_LEFT;   end
            ST_L2:     begin lights_d = 6'b011000; csl_d = CSL_LEFT;   end
            ST_L3:     begin lights_d = 6'b111000; csl_d = CSL_LEFT;   end
            ST_R1:     begin lights_d = 6'b000100; csl_d = CSL_RIGHT;  end
            ST_R2:     begin lights_d = 6'b000110; csl_d = CSL_RIGHT;  end
            ST_R3:     begin lights_d = 6'b000111; csl_d = CSL_RIGHT;  end
            ST_HZ_ON:  begin lights_d = 6'b111111; csl_d = CSL_HAZARD; end
            ST_HZ_OFF: begin lights_d = 6'b000000; csl_d = CSL_HAZARD; end
            default:   begin lights_d = 6'b000000; csl_d = CSL_IDLE;   end
        endcase
    end

    // Output registers: glitch-free lamps and mode code, cleared at once by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lights_q <= 6'b000000;
            csl_q    <= CSL_IDLE;
        end else begin
            lights_q <= lights_d;
            csl_q    <= csl_d;
        end
    end

    assign lights = lights_q;
    assign csl    = csl_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_tbird_light_ctrl.sv
// Bench for tbird_light_ctrl with TICK_DIV = 4: directed scenarios followed by
// random switch activity, every cycle compared against a mode/step reference model.
module tb_tbird_light_ctrl;

    localparam int TD = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       left_sw  = 1'b0;
    logic       right_sw = 1'b0;
    logic       haz_sw   = 1'b0;
    logic [5:0] lights;
    logic [3:0] csl;
    logic       tick;

    int total = 0;
    int bad   = 0;

    tbird_light_ctrl #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .haz_sw   (haz_sw),
        .lights   (lights),
        .csl      (csl),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Reference model: m_s = mode*4 + step, mode 0 idle / 1 left / 2 right / 3 hazard;
    // step counts lit lamps for left/right, and is 1 (on) / 0 (off) for hazard.
    int         m_s   = 0;
    int         m_cyc = 0;
    logic [1:0] hl    = 2'b00;
    logic [1:0] hr    = 2'b00;
    logic [1:0] hh    = 2'b00;

    function automatic int nxt(input int s, input bit sl, input bit sr, input bit sh);
        int  mode = s / 4;
        int  n    = s % 4;
        bit  hz   = sh | (sl & sr);
        if (mode == 3 && n == 1) return 12;
        if (mode == 0 || mode == 3) begin
            if (hz) return 13;
            if (sl) return 5;
            if (sr) return 9;
            return 0;
        end
        if (hz) return 13;
        if (n == 3) return 0;
        return s + 1;
    endfunction

    function automatic logic [7:0] exp_lights(input int s);
        int mode = s / 4;
        int n    = s % 4;
        case (mode)
            1:       return 8'(((1 << n) - 1) << 3);
            2:       return 8'((7 << (3 - n)) & 7);
            3:       return (n == 1) ? 8'h3f : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s   <= 0;
            m_cyc <= 0;
            hl    <= 2'b00;
            hr    <= 2'b00;
            hh    <= 2'b00;
        end else begin
            if (m_cyc % TD == TD - 1) m_s <= nxt(m_s, hl[1], hr[1], hh[1]);
            hl    <= {hl[0], left_sw};
            hr    <= {hr[0], right_sw};
            hh    <= {hh[0], haz_sw};
            m_cyc <= m_cyc + 1;
        end
    end

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        cmp("lights", {2'b00, lights}, exp_lights(m_s));
        cmp("csl", {4'b0000, csl}, 8'(m_s / 4));
        cmp("tick", {7'd0, tick}, {7'd0, rst_n && (m_cyc % TD == TD - 1)});
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            check_all();
            if (m_s == s) begin
                found = 1'b1;
                break;
            end
        end
        cmp("wait_timeout", {7'd0, found}, 8'd1);
    endtask

    initial begin
        // Reset held for 3 clk
        step_n(3);
        cmp("rst_lights", {2'b00, lights}, 8'h00);
        cmp("rst_csl", {4'b0000, csl}, 8'h00);
        cmp("rst_tick", {7'd0, tick}, 8'h00);
        rst_n = 1'b1;
        step_n(8);

        // Left held: full sequence and restart
        left_sw = 1'b1;
        step_n(24);
        left_sw = 1'b0;
        step_n(16);

        // Right 1-clk pulse aligned away from a tick edge: ignored
        for (int i = 0; i < TD; i++) begin
            if (m_cyc % TD == 0) break;
            step_n(1);
        end
        right_sw = 1'b1;
        step_n(1);
        right_sw = 1'b0;
        step_n(8);
        cmp("pulse_lights", {2'b00, lights}, 8'h00);
        cmp("pulse_csl", {4'b0000, csl}, 8'h00);

        // Right held for 10 clk
        right_sw = 1'b1;
        step_n(10);
        right_sw = 1'b0;
        step_n(16);

        // Hazard switch, then left+right as hazard
        haz_sw = 1'b1;
        step_n(16);
        haz_sw = 1'b0;
        step_n(8);
        left_sw  = 1'b1;
        right_sw = 1'b1;
        step_n(16);
        left_sw  = 1'b0;
        right_sw = 1'b0;
        step_n(12);

        // Hazard abort from L2
        left_sw = 1'b1;
        wait_state(6, 40);
        haz_sw  = 1'b1;
        left_sw = 1'b0;
        step_n(4);
        cmp("abort_lights", {2'b00, lights}, 8'h3f);
        cmp("abort_csl", {4'b0000, csl}, 8'h03);
        haz_sw = 1'b0;
        step_n(12);

        // Reset asserted while in R2, between clock edges
        right_sw = 1'b1;
        wait_state(10, 40);
        #3 rst_n = 1'b0;
        #1;
        cmp("midrst_lights", {2'b00, lights}, 8'h00);
        cmp("midrst_csl", {4'b0000, csl}, 8'h00);
        cmp("midrst_tick", {7'd0, tick}, 8'h00);
        right_sw = 1'b0;
        step_n(2);
        rst_n = 1'b1;
        step_n(12);

        // Random switch activity
        for (int i = 0; i < 600; i++) begin
            step_n(1);
            if ($urandom_range(0, 5) == 0) begin
                left_sw  = 1'($urandom_range(0, 1));
                right_sw = 1'($urandom_range(0, 1));
                haz_sw   = ($urandom_range(0, 3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
